// File: rtl/uart_packet_receiver.sv
// Oversampling UART receiver with configurable frame format, feeding a first-word
// fall-through FIFO that tags terminator words on a valid/ready stream.
module uart_packet_receiver #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int TERMINATOR_ENABLE = 1,
    parameter logic [DATA_BITS-1:0] TERMINATOR = '0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 uart_receive,
    output logic [DATA_BITS-1:0]                 m_data,
    output logic                                 m_last,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fill_level,
    output logic                                 parity_error,
    output logic                                 framing_error,
    output logic                                 overflow
);

    localparam int RAW_DIV = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV = (RAW_DIV < 1) ? 1 : RAW_DIV;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;

    state_t               state;
    logic                 sync0, sync1, line_prev;
    logic                 start_edge;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [OS_W-1:0]      os_cnt;
    logic                 sample_mid, sample_bit;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bad, stop_bad, finishing;

    logic [DATA_BITS:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 fifo_full, pop, frame_good, wr_en, is_last;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync0     <= 1'b1;
            sync1     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync0     <= uart_receive;
            sync1     <= sync0;
            line_prev <= sync1;
        end
    end

    assign start_edge = line_prev & ~sync1;

    // Restarting the divider on the start edge aligns every later tick to the frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if ((state == IDLE && start_edge) || div_cnt == DIV_W'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick       = (div_cnt == DIV_W'(DIV - 1));
    assign sample_mid = tick && (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
    assign sample_bit = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = m_valid && m_ready;
    assign frame_good = (state == STOP) && finishing && !stop_bad && !parity_bad;
    assign wr_en      = frame_good && (!fifo_full || pop);
    assign is_last    = (TERMINATOR_ENABLE != 0) && (shift == TERMINATOR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            os_cnt        <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            parity_bad    <= 1'b0;
            stop_bad      <= 1'b0;
            finishing     <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overflow      <= 1'b0;
            if (tick && state != IDLE) begin
                os_cnt <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + OS_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state  <= START;
                        os_cnt <= '0;
                    end
                end
                START: begin
                    if (sample_mid) begin
                        os_cnt     <= '0;
                        bit_cnt    <= '0;
                        parity_bad <= 1'b0;
                        stop_bad   <= 1'b0;
                        finishing  <= 1'b0;
                        state      <= sync1 ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sample_bit) begin
                        shift <= {sync1, shift[DATA_BITS-1:1]};
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sample_bit) begin
                        parity_bad <= ((^shift) ^ sync1) != (PARITY_MODE == 2);
                        state      <= STOP;
                    end
                end
                STOP: begin
                    // One extra cycle after the final stop sample resolves the frame outcome.
                    if (finishing) begin
                        finishing <= 1'b0;
                        if (stop_bad) begin
                            framing_error <= 1'b1;
                            state         <= RECOVER;
                        end else if (parity_bad) begin
                            parity_error <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            overflow <= fifo_full && !pop;
                            state    <= IDLE;
                        end
                    end else if (sample_bit) begin
                        if (!sync1) begin
                            stop_bad <= 1'b1;
                        end
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            finishing <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                RECOVER: begin
                    if (sync1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!wr_en && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= {is_last, shift};
        end
    end

    // Head word is gated so the stream reads as zero whenever the FIFO is empty.
    assign m_valid    = (count != '0);
    assign m_data     = m_valid ? mem[rd_ptr][DATA_BITS-1:0] : '0;
    assign m_last     = m_valid && mem[rd_ptr][DATA_BITS];
    assign fill_level = count;

endmodule

// File: tb/tb_uart_packet_receiver.sv
// Directed bench: four receiver configurations share one serial line and reset,
// each section checks the instance whose configuration it targets.
module tb_uart_packet_receiver;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_n, rx;
    logic ready_a, ready_b, ready_c, ready_d;
    logic [7:0] data_a, data_b, data_c;
    logic [6:0] data_d;
    logic last_a, last_b, last_c, last_d;
    logic valid_a, valid_b, valid_c, valid_d;
    logic [4:0] fill_a, fill_c, fill_d;
    logic [2:0] fill_b;
    logic perr_a, perr_b, perr_c, perr_d;
    logic ferr_a, ferr_b, ferr_c, ferr_d;
    logic ovf_a, ovf_b, ovf_c, ovf_d;

    int checks = 0;
    int errors = 0;

    logic [8:0] beats_a [32];
    logic [8:0] beats_b [32];
    logic [8:0] beats_c [32];
    logic [8:0] beats_d [32];
    int nb_a = 0, nb_b = 0, nb_c = 0, nb_d = 0;
    int npe_a = 0, nfe_a = 0, nov_a = 0;
    int nov_b = 0;
    int npe_c = 0, nfe_c = 0;
    int npe_d = 0, nfe_d = 0;

    uart_packet_receiver #(.CLOCK_FREQUENCY(1600), .BAUD_RATE(100)) u_a (
        .clock(clock), .reset(rst_n), .uart_receive(rx), .m_data(data_a), .m_last(last_a),
        .m_valid(valid_a), .m_ready(ready_a), .fill_level(fill_a), .parity_error(perr_a),
        .framing_error(ferr_a), .overflow(ovf_a));

    uart_packet_receiver #(.CLOCK_FREQUENCY(1600), .BAUD_RATE(100), .FIFO_DEPTH(4)) u_b (
        .clock(clock), .reset(rst_n), .uart_receive(rx), .m_data(data_b), .m_last(last_b),
        .m_valid(valid_b), .m_ready(ready_b), .fill_level(fill_b), .parity_error(perr_b),
        .framing_error(ferr_b), .overflow(ovf_b));

    uart_packet_receiver #(.CLOCK_FREQUENCY(1600), .BAUD_RATE(100), .PARITY_MODE(1)) u_c (
        .clock(clock), .reset(rst_n), .uart_receive(rx), .m_data(data_c), .m_last(last_c),
        .m_valid(valid_c), .m_ready(ready_c), .fill_level(fill_c), .parity_error(perr_c),
        .framing_error(ferr_c), .overflow(ovf_c));

    uart_packet_receiver #(.CLOCK_FREQUENCY(1600), .BAUD_RATE(100), .DATA_BITS(7),
                           .STOP_BITS(2), .PARITY_MODE(2)) u_d (
        .clock(clock), .reset(rst_n), .uart_receive(rx), .m_data(data_d), .m_last(last_d),
        .m_valid(valid_d), .m_ready(ready_d), .fill_level(fill_d), .parity_error(perr_d),
        .framing_error(ferr_d), .overflow(ovf_d));

    // Inputs change just after the rising edge, so mid-cycle samples see settled values.
    always @(negedge clock) begin
        if (rst_n === 1'b1) begin
            if (valid_a && ready_a) begin
                if (nb_a < 32) beats_a[nb_a] = {last_a, data_a};
                nb_a = nb_a + 1;
            end
            if (valid_b && ready_b) begin
                if (nb_b < 32) beats_b[nb_b] = {last_b, data_b};
                nb_b = nb_b + 1;
            end
            if (valid_c && ready_c) begin
                if (nb_c < 32) beats_c[nb_c] = {last_c, data_c};
                nb_c = nb_c + 1;
            end
            if (valid_d && ready_d) begin
                if (nb_d < 32) beats_d[nb_d] = {last_d, 1'b0, data_d};
                nb_d = nb_d + 1;
            end
            npe_a = npe_a + int'(perr_a);
            nfe_a = nfe_a + int'(ferr_a);
            nov_a = nov_a + int'(ovf_a);
            nov_b = nov_b + int'(ovf_b);
            npe_c = npe_c + int'(perr_c);
            nfe_c = nfe_c + int'(ferr_c);
            npe_d = npe_d + int'(perr_d);
            nfe_d = nfe_d + int'(ferr_d);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        step(16);
    endtask

    task automatic send_head(input int nbits, input logic [8:0] data, input int par);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
        if (par >= 0) send_bit(par[0]);
    endtask

    task automatic send_frame(input int nbits, input logic [8:0] data, input int par,
                              input int nstop, input logic [1:0] stops);
        send_head(nbits, data, par);
        for (int i = 0; i < nstop; i++) send_bit(stops[i]);
        rx = 1'b1;
        step(32);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int base, pe0, fe0, ov0;
        rst_n = 1'b0;
        rx = 1'b1;
        ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0; ready_d = 1'b0;
        step(3);
        check_value("reset_valid", 32'(valid_a), 32'd0);
        check_value("reset_data", 32'(data_a), 32'd0);
        check_value("reset_fill", 32'(fill_a), 32'd0);
        check_value("reset_pulses", {29'd0, perr_a, ferr_a, ovf_a}, 32'd0);
        rst_n = 1'b1;
        step(3);

        $display("[TB] basic framing");
        ready_a = 1'b1;
        base = nb_a; pe0 = npe_a; fe0 = nfe_a; ov0 = nov_a;
        send_frame(8, 9'h41, -1, 1, 2'b11);
        send_frame(8, 9'h42, -1, 1, 2'b11);
        send_frame(8, 9'h00, -1, 1, 2'b11);
        check_value("basic_count", 32'(nb_a - base), 32'd3);
        check_value("basic_beat0", 32'(beats_a[base]), 32'h041);
        check_value("basic_beat1", 32'(beats_a[base + 1]), 32'h042);
        check_value("basic_beat2_last", 32'(beats_a[base + 2]), 32'h100);
        check_value("basic_errors", 32'((npe_a - pe0) + (nfe_a - fe0) + (nov_a - ov0)), 32'd0);
        check_value("basic_empty", 32'(valid_a), 32'd0);

        $display("[TB] backpressure and overflow");
        apply_reset();
        base = nb_b; ov0 = nov_b;
        for (int i = 0; i < 4; i++) send_frame(8, 9'(8'h10 + i), -1, 1, 2'b11);
        check_value("bp_fill4", 32'(fill_b), 32'd4);
        check_value("bp_no_ovf_yet", 32'(nov_b - ov0), 32'd0);
        send_frame(8, 9'h14, -1, 1, 2'b11);
        check_value("bp_ovf_once", 32'(nov_b - ov0), 32'd1);
        check_value("bp_fill_held", 32'(fill_b), 32'd4);
        check_value("bp_head_hold", {23'd0, valid_b, data_b}, 32'h110);
        ready_b = 1'b1;
        step(8);
        ready_b = 1'b0;
        check_value("bp_drain_count", 32'(nb_b - base), 32'd4);
        for (int i = 0; i < 4; i++)
            check_value("bp_drain_order", 32'(beats_b[base + i]), 32'(8'h10 + i));
        check_value("bp_drained_fill", 32'(fill_b), 32'd0);

        $display("[TB] even parity");
        apply_reset();
        ready_c = 1'b1;
        base = nb_c; pe0 = npe_c; fe0 = nfe_c;
        send_frame(8, 9'h41, 0, 1, 2'b11);
        check_value("par_good_count", 32'(nb_c - base), 32'd1);
        check_value("par_good_beat", 32'(beats_c[base]), 32'h041);
        send_frame(8, 9'h41, 1, 1, 2'b11);
        check_value("par_bad_pulse", 32'(npe_c - pe0), 32'd1);
        check_value("par_bad_nowrite", 32'(nb_c - base), 32'd1);
        check_value("par_no_ferr", 32'(nfe_c - fe0), 32'd0);

        $display("[TB] framing error and recovery");
        apply_reset();
        ready_a = 1'b1;
        base = nb_a; fe0 = nfe_a; pe0 = npe_a;
        send_head(8, 9'h55, -1);
        rx = 1'b0;
        step(48);
        check_value("frm_no_write_low", 32'(nb_a - base), 32'd0);
        rx = 1'b1;
        step(32);
        send_frame(8, 9'h33, -1, 1, 2'b11);
        check_value("frm_pulse", 32'(nfe_a - fe0), 32'd1);
        check_value("frm_no_perr", 32'(npe_a - pe0), 32'd0);
        check_value("frm_next_count", 32'(nb_a - base), 32'd1);
        check_value("frm_next_beat", 32'(beats_a[base]), 32'h033);

        $display("[TB] glitch and reset mid-frame");
        apply_reset();
        ready_a = 1'b0;
        send_frame(8, 9'h99, -1, 1, 2'b11);
        check_value("gl_preload", {22'd0, fill_a[1:0], data_a}, 32'h199);
        fe0 = nfe_a; pe0 = npe_a;
        rx = 1'b0;
        step(2);
        rx = 1'b1;
        step(48);
        check_value("gl_no_write", 32'(fill_a), 32'd1);
        check_value("gl_no_error", 32'((nfe_a - fe0) + (npe_a - pe0)), 32'd0);
        send_head(4, 9'h7E, -1);
        rst_n = 1'b0;
        rx = 1'b1;
        step(2);
        check_value("rst_outputs_a", {14'd0, valid_a, last_a, data_a, fill_a, perr_a, ferr_a, ovf_a}, 32'd0);
        check_value("rst_outputs_b", {28'd0, valid_b, fill_b}, 32'd0);
        rst_n = 1'b1;
        step(32);
        ready_a = 1'b1;
        base = nb_a; fe0 = nfe_a; pe0 = npe_a;
        send_frame(8, 9'h24, -1, 1, 2'b11);
        check_value("rst_only_one", 32'(nb_a - base), 32'd1);
        check_value("rst_beat", 32'(beats_a[base]), 32'h024);
        check_value("rst_no_error", 32'((nfe_a - fe0) + (npe_a - pe0)), 32'd0);

        $display("[TB] seven bits, odd parity, two stop bits");
        apply_reset();
        ready_d = 1'b1;
        base = nb_d; fe0 = nfe_d; pe0 = npe_d;
        send_frame(7, 9'h5A, 1, 2, 2'b11);
        check_value("w7_count", 32'(nb_d - base), 32'd1);
        check_value("w7_beat", 32'(beats_d[base]), 32'h05A);
        send_frame(7, 9'h11, 1, 2, 2'b01);
        check_value("w7_frm_pulse", 32'(nfe_d - fe0), 32'd1);
        check_value("w7_no_perr", 32'(npe_d - pe0), 32'd0);
        check_value("w7_no_write", 32'(nb_d - base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_packet_receiver.md
Name: uart_packet_receiver

Overview:
Parametrised successor to the fixed 8N1 UART receive path used by the test harnesses. It oversamples the host serial line and supports configurable data width, parity and stop bits. Received words are buffered in an internal FIFO and tagged with an end-of-packet flag when the word equals a terminator. Words are presented to downstream logic on a valid/ready stream. Its intended placement is between the board UART pin and any harness DUT.

Parameters:
CLOCK_FREQUENCY, 100000000, system clock in Hz
BAUD_RATE, 115200, serial bit rate in Hz
OVERSAMPLE, 16, ticks per bit; even, >=4
DATA_BITS, 8, payload bits per frame, 5..9
PARITY_MODE, 0, 0 none, 1 even, 2 odd
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, entries; power of two, >=2
TERMINATOR_ENABLE, 1, 1 = tag words equal to TERMINATOR with m_last
TERMINATOR, 0, terminator value (DATA_BITS wide)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
uart_receive  in  1  serial line, idle high, asynchronous to clock
m_data  out  DATA_BITS  head-of-FIFO word
m_last  out  1  head word is the packet terminator
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer accepts the word when m_valid && m_ready
fill_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
parity_error  out  1  one-cycle pulse; frame dropped
framing_error  out  1  one-cycle pulse; frame dropped
overflow  out  1  one-cycle pulse; good frame dropped because the FIFO was full

Behaviour:
- Reset (reset low), all asynchronous:
  - m_valid, m_last, fill_level, parity_error, framing_error and overflow go to 0; m_data goes to 0.
  - Synchroniser flops go to 1. FSM goes to IDLE. FIFO pointers are cleared. Tick counter is cleared.
  - Reset mid-frame discards the partial frame. After release, the receiver waits for a new falling edge.
- Input: two-flop synchroniser on uart_receive. All sampling uses the second flop.
- Tick generator:
  - DIV = CLOCK_FREQUENCY / (BAUD_RATE*OVERSAMPLE), integer division, minimum 1.
  - Emits a 1-clock tick every DIV clocks.
  - Counter restarts on the start-edge detect, so the first tick comes DIV clocks after the edge.
- FSM states: IDLE, START, DATA, PARITY, STOP, RECOVER.
  - IDLE: a synchronised 1->0 transition moves to START and clears the tick count.
  - START: at tick OVERSAMPLE/2, sample the line.
    - Line high: false start, return to IDLE with no error.
    - Line low: move to DATA. Later samples are taken every OVERSAMPLE ticks.
  - DATA: DATA_BITS samples, LSB first, shifted into the word.
    - Next state is PARITY if PARITY_MODE != 0, otherwise STOP.
  - PARITY: one sample.
    - Even: XOR of data and parity bit must be 0. Odd: it must be 1.
    - The result is recorded; the frame is still timed through STOP.
  - STOP: STOP_BITS samples, each of which must be 1.
    - After the last stop sample, exactly one of the following happens on the next clock.
    - Any stop sample low: framing_error pulse, then go to RECOVER. Framing error takes priority over parity error; only one error pulses per frame.
    - Parity mismatch: parity_error pulse, then IDLE.
    - FIFO full at the write cycle: overflow pulse, then IDLE; FIFO unchanged.
    - Otherwise: write {last, word} to the FIFO, then IDLE.
    - last = TERMINATOR_ENABLE && (word == TERMINATOR).
  - RECOVER: wait until the synchronised line is 1, then go to IDLE.
- FIFO:
  - First-word fall-through: m_data/m_last reflect the head whenever m_valid=1.
  - m_valid rises the clock after the write.
  - Pop when m_valid && m_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous write and pop: both occur and fill_level is unchanged. This also applies when full: the pop frees the slot in the same cycle, so the write is accepted and there is no overflow.
  - m_ready while empty has no effect.
  - m_data/m_valid hold stable while m_valid && !m_ready.
- Latency: last stop-bit sample to m_valid=1 is 2 clocks, given the FIFO was empty and not full.

Test Plan:
- Basic framing. Setup: CLOCK_FREQUENCY=1600, BAUD_RATE=100 (DIV=1), defaults otherwise. Stimulus: send 0x41, 0x42, 0x00 with m_ready=1. Required: three beats 0x41/last=0, 0x42/last=0, 0x00/last=1, and no error pulses.
- Backpressure and overflow. Setup: FIFO_DEPTH=4, m_ready=0. Stimulus: send 0x10..0x14. Required:
  - fill_level reaches 4.
  - overflow pulses once, on the fifth frame.
  - Raising m_ready drains 0x10, 0x11, 0x12, 0x13 in order.
- Parity. Setup: PARITY_MODE=1. Stimulus: send 0x41 with parity bit 0, then 0x41 with parity bit 1. Required: first is accepted; second gives one parity_error pulse and no FIFO write.
- Framing. Stimulus: send 0x55 with stop bit 0, holding the line low for 3 bit times, then send 0x33. Required:
  - One framing_error pulse.
  - No write during the low period.
  - 0x33 is received correctly.
- Glitch and reset. Stimulus:
  - A 2-tick low glitch gives no write and no error.
  - Assert reset halfway through the DATA bits of 0x7E, release it, then send 0x24.
  Required: only 0x24 appears, and all outputs are 0 during reset.
- Width and stop bits. Setup: DATA_BITS=7, STOP_BITS=2, PARITY_MODE=2. Stimulus: send 0x5A with correct odd parity, then a frame whose second stop bit is 0. Required: 0x5A is received; the second frame gives framing_error.
